// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
// pipeline. It owns the PC, applies load-use stalls and branch/jump
// redirects, and passes opcode/func to the main control decoder in ID.
// When a STOP word (opcode 6'd63) is fetched, the stage freezes the PC. It
// then lets the older instructions drain out of ID/EX/MEM/WB and raises
// halted_o, which stays set until reset.
//
// Optional feature (macro IF_PERF_CNT_EN):
//   Defining IF_PERF_CNT_EN adds the fetch_cnt_o and stall_cnt_o
//   performance counters. The default build leaves the macro undefined and
//   has no counters.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   imem_addr_o    out  byte address to instruction memory (always the PC)
//   imem_rdata_i   in   instruction word at imem_addr_o, same cycle
//   stall_i        in   load-use stall: hold PC and IF/ID
//   redirect_i     in   resolved taken branch / jump / jr: load redirect_pc_i
//   redirect_pc_i  in   redirect target (word-aligned)
//   ifid_instr_o   out  registered instruction
//   ifid_opcode_o  out  ifid_instr_o[31:26]
//   ifid_func_o    out  ifid_instr_o[5:0]
//   ifid_pc4_o     out  registered PC+4 of ifid_instr_o
//   ifid_valid_o   out  IF/ID holds a real instruction
//   halted_o       out  processor halted; sticky until reset
//   state_o        out  FSM state (debug): 0 RUN, 1 DRAIN, 2 HALT
//   fetch_cnt_o    out  (IF_PERF_CNT_EN) valid instructions written to IF/ID
//   stall_cnt_o    out  (IF_PERF_CNT_EN) stalled edges outside HALT
//
// Handshake: IF/ID has no ready signal. ifid_valid_o qualifies the contents
// of IF/ID. stall_i acts as the backpressure: when it is high, IF/ID and the
// PC hold every field, including valid. redirect_i takes priority over
// stall_i and replaces IF/ID with a bubble (instr 0, valid 0).
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned         ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC     = '0,
    parameter int unsigned         DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [31:0]       ifid_instr_o,
    output logic [5:0]        ifid_opcode_o,
    output logic [5:0]        ifid_func_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic              ifid_valid_o,
    output logic              halted_o,
    output logic [1:0]        state_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [5:0] STOP_OPCODE = 6'd63;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic              is_stop;
    logic              fetch_inc;
    logic              stall_inc;

    // Unsigned add; 32'hFFFF_FFFC wraps to 0 by construction.
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign is_stop  = (imem_rdata_i[31:26] == STOP_OPCODE);

    // Next-state and next-register logic.
    // Priority on each edge: redirect > stall > advance.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        fetch_inc = 1'b0;

        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    // Flush the wrong-path word.
                    pc_d    = redirect_pc_i;
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    instr_d   = imem_rdata_i;
                    pc4_d     = pc_plus4;
                    valid_d   = 1'b1;
                    fetch_inc = 1'b1;
                    if (is_stop) begin
                        // STOP goes into IF/ID as a real instruction. The PC
                        // stays on it so that nothing younger is fetched.
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end

            DRAIN: begin
                if (redirect_i) begin
                    // An older branch resolved and made STOP wrong-path.
                    state_d = RUN;
                    pc_d    = redirect_pc_i;
                    instr_d = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (!stall_i) begin
                    instr_d = '0;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = HALT;
                    end
                end
            end

            HALT: begin
                // Terminal state. Only reset leaves it.
                instr_d = '0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = RUN;
                instr_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign stall_inc = stall_i && (state_q != HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Both counters wrap naturally at 2^32. They freeze in HALT because
    // neither increment condition can be true in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    // Without the counters these terms have no load. Folding them keeps
    // them referenced.
    logic unused_perf;
    assign unused_perf = fetch_inc ^ stall_inc;
`endif

    assign imem_addr_o   = pc_q;
    assign ifid_instr_o  = instr_q;
    assign ifid_opcode_o = instr_q[31:26];
    assign ifid_func_o   = instr_q[5:0];
    assign ifid_pc4_o    = pc4_q;
    assign ifid_valid_o  = valid_q;
    assign halted_o      = (state_q == HALT);
    assign state_o       = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. It models instruction memory as a small
// word array and checks the IF/ID outputs, the PC and halted_o at each
// negative clock edge against hand-computed values. The optional counters
// are checked when IF_PERF_CNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] I_ADD  = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] I_SUB  = 32'h0022_2022; // sub $4,$1,$2
    localparam logic [31:0] I_OR   = 32'h0022_2825; // or  $5,$1,$2
    localparam logic [31:0] I_STOP = 32'hFC00_0000; // STOP
    localparam logic [31:0] I_LW   = 32'h8C22_0004; // lw  $2,4($1)
    localparam logic [31:0] I_ADD2 = 32'h0109_5020; // add $10,$8,$9

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_opcode;
    logic [5:0]  ifid_func;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
    logic [1:0]  state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    logic [31:0] imem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .ifid_instr_o  (ifid_instr),
        .ifid_opcode_o (ifid_opcode),
        .ifid_func_o   (ifid_func),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_valid_o  (ifid_valid),
        .halted_o      (halted),
        .state_o       (state)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory (combinational) ----------------
    always_comb begin
        if (imem_addr[31:8] == 24'h0 && imem_addr[1:0] == 2'b00)
            imem_rdata = imem[imem_addr[7:2]];
        else
            imem_rdata = 32'h0;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks the full visible state. pc4 is only meaningful for valid entries.
    task automatic expect_st(input string tag, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid,
                             input logic [31:0] e_addr, input logic e_halted,
                             input logic [1:0] e_state);
        check({tag, ".instr"},  ifid_instr,          e_instr);
        check({tag, ".opcode"}, 32'(ifid_opcode),    32'(e_instr[31:26]));
        check({tag, ".func"},   32'(ifid_func),      32'(e_instr[5:0]));
        check({tag, ".valid"},  32'(ifid_valid),     32'(e_valid));
        check({tag, ".addr"},   imem_addr,           e_addr);
        check({tag, ".halted"}, 32'(halted),         32'(e_halted));
        check({tag, ".state"},  32'(state),          32'(e_state));
        if (e_valid) check({tag, ".pc4"}, ifid_pc4, e_pc4);
    endtask

    task automatic check_perf(input string tag, input logic [31:0] e_fetch,
                              input logic [31:0] e_stall);
`ifdef IF_PERF_CNT_EN
        check({tag, ".fetch_cnt"}, fetch_cnt, e_fetch);
        check({tag, ".stall_cnt"}, stall_cnt, e_stall);
`else
        if (tag.len() < 0) $display("%h %h", e_fetch, e_stall);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0]          = I_ADD;
        imem[1]          = I_SUB;
        imem[2]          = I_OR;
        imem[3]          = I_STOP;
        imem[32'h40 >> 2] = I_LW;
        imem[32'h80 >> 2] = I_ADD2;

        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        @(negedge clk);
        expect_st("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0);
        check("reset.pc4", ifid_pc4, 32'h0);
        check_perf("reset", 32'd0, 32'd0);
        reset = 1'b0;

        // Straight-line fetch
        tick(); expect_st("fetch0", I_ADD, 32'd4, 1'b1, 32'd4, 1'b0, 2'd0);
        tick(); expect_st("fetch4", I_SUB, 32'd8, 1'b1, 32'd8, 1'b0, 2'd0);

        // Two-cycle stall holds PC and IF/ID
        stall = 1'b1;
        tick(); expect_st("stall1", I_SUB, 32'd8, 1'b1, 32'd8, 1'b0, 2'd0);
        tick(); expect_st("stall2", I_SUB, 32'd8, 1'b1, 32'd8, 1'b0, 2'd0);
        stall = 1'b0;
        tick(); expect_st("fetch8", I_OR, 32'd12, 1'b1, 32'd12, 1'b0, 2'd0);

        // STOP drain: halted exactly four edges after STOP enters IF/ID
        tick(); expect_st("stop_in", I_STOP, 32'd16, 1'b1, 32'd12, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_st($sformatf("drain%0d", i), 32'h0, 32'h0, 1'b0, 32'd12, 1'b0, 2'd1);
        end
        tick(); expect_st("halt", 32'h0, 32'h0, 1'b0, 32'd12, 1'b1, 2'd2);
        check_perf("halt", 32'd4, 32'd2);

        // Redirect and stall ignored in HALT; counters frozen
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick(); expect_st("halt_redir0", 32'h0, 32'h0, 1'b0, 32'd12, 1'b1, 2'd2);
        tick(); expect_st("halt_redir1", 32'h0, 32'h0, 1'b0, 32'd12, 1'b1, 2'd2);
        redirect = 1'b0; stall = 1'b0;
        check_perf("halt_frozen", 32'd4, 32'd2);

        // Only reset leaves HALT
        reset = 1'b1;
        #1;
        expect_st("halt_rst", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(); expect_st("restart", I_ADD, 32'd4, 1'b1, 32'd4, 1'b0, 2'd0);

        // Redirect with a simultaneous stall: redirect wins
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick(); expect_st("redir_stall", 32'h0, 32'h0, 1'b0, 32'h40, 1'b0, 2'd0);
        redirect = 1'b0; stall = 1'b0;
        tick(); expect_st("redir_tgt", I_LW, 32'h44, 1'b1, 32'h44, 1'b0, 2'd0);

        // Wrong-path STOP: redirect two cycles into DRAIN
        redirect = 1'b1; redirect_pc = 32'd12;
        tick(); expect_st("to_stop", 32'h0, 32'h0, 1'b0, 32'd12, 1'b0, 2'd0);
        redirect = 1'b0;
        tick(); expect_st("stop2_in", I_STOP, 32'd16, 1'b1, 32'd12, 1'b0, 2'd1);
        tick(); expect_st("stop2_drain", 32'h0, 32'h0, 1'b0, 32'd12, 1'b0, 2'd1);
        redirect = 1'b1; redirect_pc = 32'h80;
        tick(); expect_st("wrong_path", 32'h0, 32'h0, 1'b0, 32'h80, 1'b0, 2'd0);
        redirect = 1'b0;
        tick(); expect_st("fetch80", I_ADD2, 32'h84, 1'b1, 32'h84, 1'b0, 2'd0);
        tick(); expect_st("fetch84", 32'h0, 32'h88, 1'b1, 32'h88, 1'b0, 2'd0);

        // Async reset asserted between edges in DRAIN
        redirect = 1'b1; redirect_pc = 32'd12;
        tick(); expect_st("to_stop3", 32'h0, 32'h0, 1'b0, 32'd12, 1'b0, 2'd0);
        redirect = 1'b0;
        tick(); expect_st("stop3_in", I_STOP, 32'd16, 1'b1, 32'd12, 1'b0, 2'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        expect_st("async_rst", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0);
        check("async_rst.pc4", ifid_pc4, 32'h0);
        check_perf("async_rst", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(); expect_st("after_rst", I_ADD, 32'd4, 1'b1, 32'd4, 1'b0, 2'd0);
        tick(); expect_st("after_rst4", I_SUB, 32'd8, 1'b1, 32'd8, 1'b0, 2'd0);
        check_perf("after_rst", 32'd2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Produces the opcode/func fields consumed by the main control decoder in ID.
- Owns the PC and applies stalls from hazard detection and redirects from branch/jump resolution.
- Detects the STOP instruction (opcode 6'd63), drains the pipeline, then raises halted.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DRAIN_CYCLES, 4, cycles after STOP enters IF/ID before halted_o asserts (covers ID/EX/MEM/WB)
ADDR_W, 32, PC / instruction-memory address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_addr_o  output  ADDR_W  byte address to instruction memory; equals PC; combinational read
imem_rdata_i  input  32  instruction word at imem_addr_o, same cycle
stall_i  input  1  load-use stall; hold PC and IF/ID
redirect_i  input  1  taken branch, jump or jr resolved; load redirect_pc_i
redirect_pc_i  input  ADDR_W  redirect target, word-aligned
ifid_instr_o  output  32  registered instruction
ifid_opcode_o  output  6  ifid_instr_o[31:26]
ifid_func_o  output  6  ifid_instr_o[5:0]
ifid_pc4_o  output  ADDR_W  registered PC+4 of ifid_instr_o
ifid_valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  processor halted; sticky until reset

Behaviour:
- Reset (async, any state): PC=RESET_PC; ifid_instr_o=0; ifid_pc4_o=0; ifid_valid_o=0; halted_o=0; drain counter=0; state=RUN.
- Bubble = instr 32'h0000_0000 (sll $0,$0,0, architectural no-op) with valid=0.
- Per-edge priority: reset > redirect_i > stall_i > normal advance.
- State RUN:
  - Normal advance: IF/ID <= {imem_rdata_i, PC+4, valid=1}; PC <= PC+4. Latency: instruction at PC appears on ifid_* one cycle later.
  - stall_i=1: PC and IF/ID hold all values, including valid.
  - redirect_i=1: PC <= redirect_pc_i; IF/ID <= bubble (wrong-path flush). Overrides a simultaneous stall.
  - Fetched word has opcode 6'd63 on a normal advance: latch it into IF/ID as valid; PC holds; counter=0; go to DRAIN.
- State DRAIN:
  - PC frozen. IF/ID <= bubble each cycle after the STOP word leaves, unless stalled.
  - A stall holds IF/ID and counter.
  - Counter increments on each non-stalled cycle. At counter==DRAIN_CYCLES-1, go to HALT and set halted_o=1 on that edge.
  - redirect_i=1 (older branch made STOP wrong-path): PC <= redirect_pc_i; IF/ID <= bubble; counter=0; return to RUN.
- State HALT:
  - PC frozen; IF/ID bubble; halted_o=1.
  - redirect_i and stall_i ignored; exit only via reset.
- PC arithmetic: ADDR_W-bit unsigned add, wraps 32'hFFFF_FFFC -> 0. imem_addr_o is always PC, no alignment check.
- ifid_opcode_o and ifid_func_o are pure slices of the registered instruction; no extra latency.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on every edge that writes a valid instruction into IF/ID.
  - stall_cnt_o increments on every edge with stall_i=1 and state!=HALT.
  - Both wrap at 2^32 and freeze in HALT.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Straight-line: imem holds add/sub/or at 0,4,8; no stall -> ifid_instr_o follows words in order, ifid_pc4_o = 4, 8, 12, ifid_valid_o=1 from first edge after reset.
- Stall: assert stall_i for 2 cycles while IF/ID holds the word from addr 4 -> PC stays 8, ifid_* unchanged for 2 cycles, then the word at 8 is latched.
- Redirect with simultaneous stall: redirect_i=1, redirect_pc_i=32'h40, stall_i=1 -> next edge PC=32'h40 and IF/ID bubble (valid=0, instr=0); following edge latches the word at 32'h40.
- STOP drain: 32'hFC00_0000 at addr 12 -> STOP latched valid, then 3 bubbles, halted_o=1 exactly DRAIN_CYCLES=4 edges after STOP enters IF/ID; PC stays 12; a later redirect is ignored.
- Wrong-path STOP: redirect to 32'h80 two cycles after entering DRAIN -> state RUN, halted_o stays 0, word at 32'h80 fetched.
- Async reset mid-DRAIN, asserted between edges -> outputs clear immediately; after release PC=RESET_PC and fetch restarts; with IF_PERF_CNT_EN, both counters read 0.
